div_arbiter: RTL
================

// Module: div_arbiter
// PURPOSE
//  Shares one iterative unsigned divider among N_REQ requesters. One operation in flight at a time.
//  Round-robin grant, latches operands, sequences divider start/finish, returns tagged Q/R on a broadcast bus.
//  Divide-by-zero is resolved locally and never issued to the divider. Sits between client FSMs and the divider.
// PARAMETERS
//  N_REQ    4    number of requesters (>=2); ID_W = $clog2(N_REQ) derived localparam
//  WIDTH    8    operand / quotient / remainder width (matches divider WIDTH)
//  TIMEOUT  64   max WAIT cycles before abort (used only with DIV_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rst        in   1            synchronous active-high reset
//  req        in   N_REQ        level request per requester, held until gnt
//  a_in       in   N_REQ*WIDTH  dividends, slice i = a_in[i*WIDTH +: WIDTH]
//  b_in       in   N_REQ*WIDTH  divisors, same slicing
//  gnt        out  N_REQ        one-hot 1-cycle pulse: operands of that requester sampled this cycle
//  rsp_valid  out  1            1-cycle result strobe
//  rsp_id     out  ID_W         requester index of the result
//  rsp_q      out  WIDTH        quotient
//  rsp_r      out  WIDTH        remainder
//  rsp_dbz    out  1            divisor was zero
//  rsp_err    out  1            divider timed out (0 unless DIV_ARB_TIMEOUT_EN)
//  div_en     out  1            divider start, 1-cycle pulse
//  div_a      out  WIDTH        dividend to divider, stable from ISSUE until RESP
//  div_b      out  WIDTH        divisor to divider, stable from ISSUE until RESP (never 0 while in ISSUE/WAIT)
//  div_q      in   WIDTH        divider quotient
//  div_r      in   WIDTH        divider remainder
//  div_valid  in   1            divider done
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, every output 0. Reset mid-operation abandons the op, no rsp_valid; divider shares rst.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if |req, winner = first set req at or after rr_ptr (wrapping N_REQ-1 -> 0); gnt[winner]=1 this cycle;
//        latch id, a, b. b==0 -> RESP with q={WIDTH{1'b1}}, r=a, dbz=1. Else -> ISSUE. No req: stay.
//  ISSUE: div_en=1 for exactly one cycle -> WAIT.
//  WAIT: div_valid sampled only here; first high cycle captures div_q/div_r -> RESP. div_valid outside WAIT ignored.
//  RESP: rsp_valid=1 one cycle with id/q/r/dbz/err; rsp_* hold value until next RESP. rr_ptr = id+1 (wrap) -> IDLE.
//  No grant issued in ISSUE/WAIT/RESP; req arriving then waits. Requester may drop req before gnt, no side effect.
//  Latency gnt->rsp_valid: 1 cycle for dbz; 3 + divider latency otherwise. Back-to-back grants >= 1 IDLE cycle apart.
//  Fairness: requester holding req granted within N_REQ operations.
//  Simultaneous req in IDLE: exactly one gnt bit, chosen per rr_ptr.
// CONFIGURATION
//  DIV_ARB_TIMEOUT_EN defined: WAIT counter cleared on entry; reaching TIMEOUT cycles without div_valid -> RESP
//    with rsp_err=1, q=r=0, dbz=0. div_valid arriving in the same cycle as timeout wins (normal result, err=0).
//  Not defined: no counter, WAIT waits indefinitely, rsp_err tied 0.
// STRUCTURE
//  div_arb_pkg: state encoding (IDLE/ISSUE/WAIT/RESP), DBZ_Q all-ones constant.
//  Sub-module rr_pick: combinational N_REQ-bit round-robin picker (req, ptr -> one-hot grant, index, any).
//  Top holds FSM, operand/result registers, rr_ptr, optional timeout counter.
// TESTING
//  Bench pairs div_arbiter with the team's iterative divider (WIDTH=8, N_REQ=4).
//  req=0001, a=100, b=7 -> gnt=0001; later rsp_valid, id=0, q=14, r=2, dbz=0.
//  req=1111 held, distinct operands -> grant order 0,1,2,3,0; each rsp_id matches preceding gnt.
//  req[2], b=0, a=55 -> rsp_valid 1 cycle after gnt, id=2, q=255, r=55, dbz=1; div_en never pulses.
//  rst during WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid; new req=0010 served normally, grant to 1.
//  With DIV_ARB_TIMEOUT_EN, div_valid held 0 -> rsp_valid exactly TIMEOUT cycles after WAIT entry, err=1, q=r=0.
//  req[3] pulsed while WAIT, dropped before RESP -> no gnt[3]; rr_ptr advances only past the served id.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared state encoding and constants for div_arbiter and its round-robin picker.
package div_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_e;

    // Quotient reported for a zero divisor; truncated to WIDTH at the use site.
    localparam logic [63:0] DBZ_Q = '1;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/div_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module div_arb_rr_pick
    import div_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_c,
    output logic [ID_W-1:0]  idx_c,
    output logic             any_c
);

    always_comb begin
        logic [ID_W-1:0] j;
        j     = '0;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = ID_W'((32'(ptr) + i) % N_REQ);
            if (!any_c && req[j]) begin
                any_c    = 1'b1;
                gnt_c[j] = 1'b1;
                idx_c    = j;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among N_REQ clients; divide-by-zero answered locally.
// Optional WAIT timeout abort enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_q,
    output logic [WIDTH-1:0]       rsp_r,
    output logic                   rsp_dbz,
    output logic                   rsp_err,
    output logic                   div_en,
    output logic [WIDTH-1:0]       div_a,
    output logic [WIDTH-1:0]       div_b,
    input  logic [WIDTH-1:0]       div_q,
    input  logic [WIDTH-1:0]       div_r,
    input  logic                   div_valid
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             div_en_q, div_en_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_quo_q, rsp_quo_d, rsp_rem_q, rsp_rem_d;
    logic             rsp_dbz_q, rsp_dbz_d, rsp_err_q, rsp_err_d;
    logic [N_REQ-1:0] gnt_c, pick_gnt_c;
    logic [ID_W-1:0]  pick_idx_c;
    logic             pick_any_c;
    logic [WIDTH-1:0] a_sel_c, b_sel_c;
    logic             timeout_c;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    // Fires on the last of TIMEOUT WAIT cycles so the response lands TIMEOUT cycles after entry.
    assign timeout_c = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    div_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .gnt_c (pick_gnt_c),
        .idx_c (pick_idx_c),
        .any_c (pick_any_c)
    );

    // One-hot operand mux driven by the picker.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_gnt_c[i]) begin
                a_sel_c = a_in[i*WIDTH +: WIDTH];
                b_sel_c = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        div_en_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_quo_d   = rsp_quo_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_dbz_d   = rsp_dbz_q;
        rsp_err_d   = rsp_err_q;
        gnt_c       = '0;
`ifdef DIV_ARB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_any_c && !rst) begin
                    gnt_c = pick_gnt_c;
                    id_d  = pick_idx_c;
                    a_d   = a_sel_c;
                    b_d   = b_sel_c;
                    if (b_sel_c == '0) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = pick_idx_c;
                        rsp_quo_d   = WIDTH'(DBZ_Q);
                        rsp_rem_d   = a_sel_c;
                        rsp_dbz_d   = 1'b1;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d  = S_ISSUE;
                        div_en_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle takes priority over the abort.
                if (div_valid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_quo_d   = div_q;
                    rsp_rem_d   = div_r;
                    rsp_dbz_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                end else if (timeout_c) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_quo_d   = '0;
                    rsp_rem_d   = '0;
                    rsp_dbz_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                rr_ptr_d = ID_W'(wrap_inc(32'(id_q), N_REQ));
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            div_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_dbz_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            div_en_q    <= div_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_dbz_q   <= rsp_dbz_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DIV_ARB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_quo_q;
    assign rsp_r     = rsp_rem_q;
    assign rsp_dbz   = rsp_dbz_q;
    assign rsp_err   = rsp_err_q;
    assign div_en    = div_en_q;
    assign div_a     = a_q;
    assign div_b     = b_q;

endmodule
